// File: rtl/sargantana_icache_pkg.sv
// Shared icache types: way/set index widths and the replacement-policy selector.
package sargantana_icache_pkg;

   localparam int ICACHE_N_WAY       = 4;
   localparam int ICACHE_N_SET       = 64;
   localparam int ICACHE_N_WAY_CLOG2 = $clog2(ICACHE_N_WAY);
   localparam int ICACHE_SET_CLOG2   = $clog2(ICACHE_N_SET);

   typedef logic [ICACHE_N_WAY_CLOG2-1:0] way_idx_t;
   typedef logic [ICACHE_SET_CLOG2-1:0]   set_idx_t;

   typedef enum logic {
      PLRU = 1'b0,
      RR   = 1'b1
   } repl_mode_e;

endpackage

// File: rtl/sargantana_icache_ffs.sv
// Lowest-set-bit finder: index of the lowest 1 in in_i, empty_o when no bit is set.
module sargantana_icache_ffs #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     in_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             empty_o
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx_o   = '0;
      empty_o = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (in_i[i]) begin
            idx_o   = i[IDX_W-1:0];
            empty_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sargantana_icache_repl_sel.sv
// Per-set icache victim-way selector: invalid ways first, otherwise tree-PLRU or
// round-robin replacement state owned here and updated on hits and fill commits.
module sargantana_icache_repl_sel
   import sargantana_icache_pkg::*;
#(
   parameter int         N_WAY = 4,
   parameter int         N_SET = 64,
   parameter repl_mode_e MODE  = PLRU,
   localparam int        WAY_W = $clog2(N_WAY),
   localparam int        SET_W = $clog2(N_SET)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   input  logic [SET_W-1:0] req_set_i,
   input  logic [N_WAY-1:0] req_valid_bits_i,
   input  logic             hit_valid_i,
   input  logic [SET_W-1:0] hit_set_i,
   input  logic [WAY_W-1:0] hit_way_i,
   input  logic             fill_valid_i,
   input  logic [SET_W-1:0] fill_set_i,
   input  logic [WAY_W-1:0] fill_way_i,
   output logic             victim_valid_o,
   output logic [WAY_W-1:0] victim_way_o,
   output logic             victim_inval_o
);

   // Valid-only interface, no ready: each req_valid_i cycle yields exactly one
   // victim_valid_o pulse one cycle later, which the consumer must take then.

   logic [WAY_W-1:0] free_way;
   logic             all_valid;
   logic [WAY_W-1:0] policy_way;

   sargantana_icache_ffs #(.N(N_WAY), .IDX_W(WAY_W)) u_ffs (
      .in_i    (~req_valid_bits_i),
      .idx_o   (free_way),
      .empty_o (all_valid)
   );

   // Point every node on the way's root-to-leaf path away from that way.
   function automatic logic [N_WAY-2:0] plru_touch(input logic [N_WAY-2:0] tree,
                                                   input logic [WAY_W-1:0] way);
      logic [N_WAY-2:0] res;
      int               node;
      res  = tree;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         res[node] = ~way[WAY_W-1-l];
         node      = 2 * node + 1 + int'(way[WAY_W-1-l]);
      end
      return res;
   endfunction

   function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAY-2:0] tree);
      logic [WAY_W-1:0] way;
      int               node;
      way  = '0;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         way[WAY_W-1-l] = tree[node];
         node           = 2 * node + 1 + int'(tree[node]);
      end
      return way;
   endfunction

   generate
      if (MODE == PLRU) begin : g_plru
         logic [N_WAY-2:0] tree_q [N_SET];
         logic [N_WAY-2:0] hit_next;
         logic [N_WAY-2:0] fill_base;
         logic [N_WAY-2:0] fill_next;

         // A same-set fill is layered on top of the hit so it wins shared nodes.
         always_comb begin
            hit_next  = plru_touch(tree_q[hit_set_i], hit_way_i);
            fill_base = (hit_valid_i && (hit_set_i == fill_set_i)) ? hit_next
                                                                   : tree_q[fill_set_i];
            fill_next = plru_touch(fill_base, fill_way_i);
         end

         assign policy_way = plru_victim(tree_q[req_set_i]);

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               for (int s = 0; s < N_SET; s++) tree_q[s] <= '0;
            end else if (flush_i) begin
               for (int s = 0; s < N_SET; s++) tree_q[s] <= '0;
            end else begin
               if (hit_valid_i)  tree_q[hit_set_i]  <= hit_next;
               if (fill_valid_i) tree_q[fill_set_i] <= fill_next;
            end
         end
      end else begin : g_rr
         logic [WAY_W-1:0] ptr_q [N_SET];

         assign policy_way = ptr_q[req_set_i];

         // Pointer width is exact, so the increment wraps N_WAY-1 -> 0 by itself.
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               for (int s = 0; s < N_SET; s++) ptr_q[s] <= '0;
            end else if (flush_i) begin
               for (int s = 0; s < N_SET; s++) ptr_q[s] <= '0;
            end else if (fill_valid_i) begin
               ptr_q[fill_set_i] <= ptr_q[fill_set_i] + 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         victim_valid_o <= 1'b0;
         victim_way_o   <= '0;
         victim_inval_o <= 1'b0;
      end else begin
         victim_valid_o <= req_valid_i;
         if (req_valid_i) begin
            victim_way_o   <= all_valid ? policy_way : free_way;
            victim_inval_o <= ~all_valid;
         end
      end
   end

endmodule
